march_element_sequencer: RTL
============================

// Module: march_element_sequencer
// PURPOSE
//  Sequences one march element of the PMBIST cycle controller. Latches the instruction
//  fields (ops, polarities, op count, direction), walks the op slots 0..no for every
//  address, steps the address up or down across the array, and signals completion.
//  Sits between the instruction register and the memory-side op/address drivers.
// PARAMETERS
//  cs   2   op-slot counter width; also the width of no_in (max 4 ops per element)
//  aw   8   memory address width
//  opw  4   encoded width of a single operation
// PORTS
//  clk          in   1         clock; all state updates on posedge
//  r_in         in   1         reset, synchronous, active-high
//  start_in     in   1         start element; accepted only in IDLE
//  op_in        in   4*opw     packed ops; slot k = op_in[opw*k +: opw]
//  pol_in       in   4         data polarity per slot; slot k = pol_in[k]
//  no_in        in   cs        index of last op slot (ops per address = no_in+1)
//  updwn_in     in   1         1 = ascending address order, 0 = descending
//  addr_max_in  in   aw        highest address in the array
//  stall_in     in   1         1 = freeze sequencer this cycle
//  op_out       out  opw       current operation (registered)
//  pol_out      out  1         current polarity (registered)
//  addr_out     out  aw        current address (registered)
//  op_valid_out out  1         op_out/pol_out/addr_out valid this cycle
//  last_op_out  out  1         current op is the last slot at the terminal address
//  busy_out     out  1         state != IDLE
//  done_out     out  1         one-cycle pulse on element completion
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; slot counter 0; latched fields 0. Reset is
//    honoured in any state and aborts an element mid-operation with no done_out.
//  - States: IDLE, RUN, DONE (+PAUSE when the optional feature is compiled in).
//  - IDLE: start_in=1 latches op_in, pol_in, no_in, updwn_in, addr_max_in; slot=0;
//    addr = 0 if ascending, addr_max_in if descending; -> RUN. Inputs are not
//    re-sampled until the next accepted start.
//  - RUN, stall_in=0: emit slot's op/pol/addr with op_valid_out=1, first op valid on
//    the cycle after start is accepted. slot<no: slot+1. slot==no: slot=0 and addr
//    steps +1 (ascending) or -1 (descending). slot==no at terminal address (addr_max
//    ascending, 0 descending): last_op_out=1 on that op; next state DONE (or PAUSE).
//  - RUN, stall_in=1: all registers hold; op_valid_out=0 for that cycle; no op lost.
//  - DONE: done_out=1, op_valid_out=0 for exactly one cycle; -> IDLE. busy_out drops
//    in the cycle after DONE.
//  - start_in outside IDLE is ignored. start_in during DONE is ignored.
//  - Slot counter wraps naturally at 2^cs; no_in=3 uses all 4 slots. Address
//    arithmetic is mod 2^aw but never wraps because the terminal test fires first.
//  - addr_max_in=0: one address, element = no_in+1 ops, then DONE.
//  - Total ops per element = (addr_max+1)*(no+1); cycles = ops + stalls + 1 (DONE).
// CONFIGURATION
//  Macro MES_PAUSE_EN:
//  - Defined: adds input pause_len_in [15:0] (latched on start) and state PAUSE.
//    After the terminal op, if pause_len>0, stays in PAUSE for pause_len cycles
//    (op_valid_out=0, busy_out=1, stall_in ignored) before DONE; pause_len=0 goes
//    straight to DONE. Used for data-retention tests.
//  - Undefined: no port, no PAUSE state; terminal op always goes straight to DONE.
// TESTING
//  1. Reset then start, up, addr_max=3, no=1, ops {A,B}: 8 ops A0 B0 A1 B1 .. A3 B3,
//     last_op_out only on B3, done_out the following cycle, busy_out low next.
//  2. Down, addr_max=2, no=3, ops {1,2,3,4}, pol=4'b1010: addresses 2,1,0 each with
//     ops 1,2,3,4, pol 0,1,0,1; 12 valid cycles then done_out.
//  3. stall_in high for 3 cycles mid-element: outputs frozen, op_valid_out=0, sequence
//     resumes with the same op; total cycles increase by exactly 3.
//  4. addr_max=0, no=0: one op at addr 0 with last_op_out=1, then done_out; start_in
//     pulsed during RUN and DONE has no effect.
//  5. r_in asserted mid-RUN: next cycle all outputs 0, IDLE, no done_out; new start
//     runs a full element from the beginning.
//  6. MES_PAUSE_EN, pause_len=5: 5 idle busy cycles after terminal op, then done_out;
//     pause_len=0 behaves as without the macro.

Source files
------------

// File: rtl/march_element_sequencer.sv
// march_element_sequencer: walks one march element (op slots x addresses) and
// presents registered op/polarity/address to the memory-side drivers.
// Optional feature macro: MES_PAUSE_EN (adds pause_len_in and a PAUSE state
// inserted between the terminal op and DONE, for data-retention tests).
module march_element_sequencer #(
    parameter int cs  = 2,
    parameter int aw  = 8,
    parameter int opw = 4
) (
    input  logic                clk,
    input  logic                r_in,
    input  logic                start_in,
    input  logic [4*opw-1:0]    op_in,
    input  logic [3:0]          pol_in,
    input  logic [cs-1:0]       no_in,
    input  logic                updwn_in,
    input  logic [aw-1:0]       addr_max_in,
    input  logic                stall_in,
`ifdef MES_PAUSE_EN
    input  logic [15:0]         pause_len_in,
`endif
    output logic [opw-1:0]      op_out,
    output logic                pol_out,
    output logic [aw-1:0]       addr_out,
    output logic                op_valid_out,
    output logic                last_op_out,
    output logic                busy_out,
    output logic                done_out
);

`ifdef MES_PAUSE_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [4*opw-1:0]   ops_q, ops_d;
    logic [3:0]         pols_q, pols_d;
    logic [cs-1:0]      no_q, no_d;
    logic               up_q, up_d;
    logic [aw-1:0]      amax_q, amax_d;
    // slot_q/addr_q always index the op currently presented on the outputs
    logic [cs-1:0]      slot_q, slot_d;
    logic [aw-1:0]      addr_q, addr_d;
    logic [opw-1:0]     op_q, op_d;
    logic               pol_q, pol_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
`ifdef MES_PAUSE_EN
    logic [15:0]        plen_q, plen_d;
    logic [15:0]        pcnt_q, pcnt_d;
`endif

    logic [cs-1:0]      nslot;
    logic [aw-1:0]      naddr;

    // Next-state and next-output computation for the element walk
    always_comb begin
        state_d = state_q;
        ops_d   = ops_q;
        pols_d  = pols_q;
        no_d    = no_q;
        up_d    = up_q;
        amax_d  = amax_q;
        slot_d  = slot_q;
        addr_d  = addr_q;
        op_d    = op_q;
        pol_d   = pol_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        nslot   = slot_q;
        naddr   = addr_q;
`ifdef MES_PAUSE_EN
        plen_d  = plen_q;
        pcnt_d  = pcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    ops_d   = op_in;
                    pols_d  = pol_in;
                    no_d    = no_in;
                    up_d    = updwn_in;
                    amax_d  = addr_max_in;
`ifdef MES_PAUSE_EN
                    plen_d  = pause_len_in;
`endif
                    slot_d  = '0;
                    addr_d  = updwn_in ? '0 : addr_max_in;
                    op_d    = op_in[opw-1:0];
                    pol_d   = pol_in[0];
                    valid_d = 1'b1;
                    // Start address is terminal only for a single-address array
                    last_d  = (no_in == '0) && (addr_max_in == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall_in) begin
                    if (last_q) begin
                        slot_d  = '0;
                        addr_d  = '0;
                        op_d    = '0;
                        pol_d   = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
`ifdef MES_PAUSE_EN
                        if (plen_q != 16'd0) begin
                            pcnt_d  = plen_q;
                            state_d = PAUSE;
                        end else begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
`else
                        done_d  = 1'b1;
                        state_d = DONE;
`endif
                    end else begin
                        if (slot_q == no_q) begin
                            nslot = '0;
                            naddr = up_q ? addr_q + aw'(1) : addr_q - aw'(1);
                        end else begin
                            nslot = slot_q + cs'(1);
                            naddr = addr_q;
                        end
                        slot_d = nslot;
                        addr_d = naddr;
                        op_d   = ops_q[opw*int'(nslot) +: opw];
                        pol_d  = pols_q[nslot];
                        last_d = (nslot == no_q) && (naddr == (up_q ? amax_q : '0));
                    end
                end
            end
`ifdef MES_PAUSE_EN
            PAUSE: begin
                pcnt_d = pcnt_q - 16'd1;
                if (pcnt_q == 16'd1) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (r_in) begin
            state_q <= IDLE;
            ops_q   <= '0;
            pols_q  <= '0;
            no_q    <= '0;
            up_q    <= 1'b0;
            amax_q  <= '0;
            slot_q  <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            pol_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MES_PAUSE_EN
            plen_q  <= '0;
            pcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
            pols_q  <= pols_d;
            no_q    <= no_d;
            up_q    <= up_d;
            amax_q  <= amax_d;
            slot_q  <= slot_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            pol_q   <= pol_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef MES_PAUSE_EN
            plen_q  <= plen_d;
            pcnt_q  <= pcnt_d;
`endif
        end
    end

    // A stalled cycle presents the held op but marks it not issued
    assign op_out       = op_q;
    assign pol_out      = pol_q;
    assign addr_out     = addr_q;
    assign op_valid_out = valid_q & ~stall_in;
    assign last_op_out  = last_q & ~stall_in;
    assign busy_out     = (state_q != IDLE);
    assign done_out     = done_q;

endmodule
